// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    LD   = 2'b11
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane alignment for the load/store unit: extracts and extends the addressed
// byte/half of a memory word for loads, and merges store data into the
// addressed lane of a memory word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane extraction with sign/zero extension, and lane replacement for stores.
  always_comb begin
    byte_s     = word[{offset, 3'b000} +: 8];
    half_s     = word[{offset[1], 4'b0000} +: 16];
    load_data  = word;
    store_data = wdata;
    case (size_t'(size))
      SZ_BYTE: begin
        load_data  = {{24{~is_unsigned & byte_s[7]}}, byte_s};
        store_data = word;
        store_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{~is_unsigned & half_s[15]}}, half_s};
        store_data = word;
        store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide synchronous
// data memory. Sub-word stores are done as read-modify-write because the
// memory has no byte enables.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned/reserved requests
// complete immediately with err_o instead of being force-aligned).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_we_o,
  input  logic [31:0]       mem_rdata_i
);

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          off_r;
  size_t               size_r;
  logic                we_r;
  logic                uns_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                done_r;
  logic                err_r;

  size_t               req_size_s;
  logic [1:0]          req_off_s;
  logic                misalign_s;
  logic [DATA_W-1:0]   load_data_s;
  logic [DATA_W-1:0]   store_data_s;

  // Request decode: either trap misaligned/reserved requests or force-align them.
  always_comb begin
    req_size_s = size_t'(size_i);
    req_off_s  = addr_i[1:0];
    misalign_s = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (size_i)
      2'b01:   misalign_s = addr_i[0];
      2'b10:   misalign_s = (addr_i[1:0] != 2'b00);
      2'b11:   misalign_s = 1'b1;
      default: misalign_s = 1'b0;
    endcase
`else
    case (size_i)
      2'b00:   req_off_s = addr_i[1:0];
      2'b01:   req_off_s = {addr_i[1], 1'b0};
      default: begin
        req_size_s = SZ_WORD;
        req_off_s  = 2'b00;
      end
    endcase
`endif
  end

  // During WR the memory's output register still holds the word read in RD,
  // so the sub-word merge is taken directly from mem_rdata_i.
  lsu_lane_align u_align (
    .size        (size_r),
    .offset      (off_r),
    .is_unsigned (uns_r),
    .word        (mem_rdata_i),
    .wdata       (wdata_r),
    .load_data   (load_data_s),
    .store_data  (store_data_s)
  );

  // Sequencer FSM with request latches and registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      off_r   <= 2'b00;
      size_r  <= SZ_BYTE;
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_i) begin
            addr_r  <= addr_i[ADDR_W+1:2];
            off_r   <= req_off_s;
            size_r  <= req_size_s;
            we_r    <= we_i;
            uns_r   <= unsigned_i;
            wdata_r <= wdata_i;
            if (misalign_s) begin
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              state_r <= IDLE;
            end else if (we_i && (req_size_s == SZ_WORD)) begin
              state_r <= WR;
            end else begin
              state_r <= RD;
            end
          end
        end
        RD:      state_r <= we_r ? WR : LD;
        WR: begin
          state_r <= IDLE;
          done_r  <= 1'b1;
        end
        LD: begin
          state_r <= IDLE;
          done_r  <= 1'b1;
          rdata_r <= load_data_s;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Memory interface driven from state and latched request fields.
  always_comb begin
    mem_addr_o  = {ADDR_W{1'b0}};
    mem_wdata_o = 32'h0000_0000;
    if ((state_r == RD) || (state_r == WR)) begin
      mem_addr_o = addr_r;
    end else begin
      mem_addr_o = {ADDR_W{1'b0}};
    end
    if (state_r == WR) begin
      mem_wdata_o = store_data_s;
    end else begin
      mem_wdata_o = 32'h0000_0000;
    end
  end

  // A write cut short by reset must never reach the memory.
  assign mem_we_o = (state_r == WR) & ~rst;
  assign ready_o  = (state_r == IDLE);
  assign done_o   = done_r;
  assign err_o    = err_r;
  assign rdata_o  = rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// requests checked against a word-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        ready_o, done_o, err_o, mem_we_o;
  logic [31:0] rdata_o, mem_wdata_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] dmem    [0:4095];
  logic [31:0] ref_mem [0:4095];
  int          vectors = 0;
  int          miscompares = 0;
  int          we_cnt = 0;
  int          cyc = 0;
  int          last_we_cyc = -1;
  logic [31:0] exp_rdata = 32'h0;

  load_store_unit #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read-before-write, 1-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we_o) dmem[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= dmem[mem_addr_o];
  end

  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      we_cnt      = we_cnt + 1;
      last_we_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int offs(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return int'(a[1:0]);
    if (sz == 2'b01) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic is_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b11);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    longint unsigned w, mask, v;
    int n, off;
    n    = nbytes(sz);
    off  = offs(sz, a);
    w    = longint'({32'd0, ref_mem[a[13:2]]});
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = (w >> (8 * off)) & mask;
    if (!uns && n < 4 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | (64'hFFFF_FFFF ^ mask);
    return 32'(v);
  endfunction

  function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    longint unsigned w, mask, msh, d;
    int n, off;
    n    = nbytes(sz);
    off  = offs(sz, a);
    w    = longint'({32'd0, ref_mem[a[13:2]]});
    mask = (64'd1 << (8 * n)) - 64'd1;
    msh  = mask << (8 * off);
    d    = (longint'({32'd0, wd}) & mask) << (8 * off);
    ref_mem[a[13:2]] = 32'((w & ~msh) | d);
  endfunction

  // Issue one request (called just after a posedge with the DUT idle) and check it.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int lat, we0, c0, exp_lat;
    logic trap;
    trap    = is_trap(sz, a);
    exp_lat = trap ? 1 : (we && nbytes(sz) == 4) ? 2 : 3;
    check("ready_before_req", {31'd0, ready_o}, 32'd1);
    we0 = we_cnt;
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    req_i = 1'b0; we_i = $urandom; addr_i = $urandom; wdata_i = $urandom;
    c0  = cyc;
    lat = 1;
    while (done_o !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat = lat + 1;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("err", {31'd0, err_o}, {31'd0, trap});
    check("ready_in_done", {31'd0, ready_o}, 32'd1);
    if (!trap && !we) exp_rdata = model_load(sz, uns, a);
    check("rdata", rdata_o, exp_rdata);
    check("we_count", 32'(we_cnt - we0), (!trap && we) ? 32'd1 : 32'd0);
    if (!trap && we) begin
      check("we_cycle", 32'(last_we_cyc), 32'(c0 + exp_lat - 2));
      model_store(sz, a, wd);
      check("mem_word", dmem[a[13:2]], ref_mem[a[13:2]]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) begin
      dmem[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store then word load.
    run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("t1_load", rdata_o, 32'hDEAD_BEEF);

    // Byte lanes with sign/zero extension and byte merge.
    run_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
    run_op(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
    check("t2_lb_23", rdata_o, 32'h0000_0011);
    run_op(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0080);
    run_op(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    check("t2_lb_21", rdata_o, 32'hFFFF_FF80);
    run_op(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    check("t2_lbu_21", rdata_o, 32'h0000_0080);
    check("t2_word", dmem[8], 32'h1122_8044);

    // Half store over a zero word, signed half load.
    run_op(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_ABCD);
    check("t3_word", dmem[12], 32'hABCD_0000);
    run_op(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    check("t3_lh", rdata_o, 32'hFFFF_ABCD);

    // Misaligned word load.
    run_op(1'b1, 2'b10, 1'b0, 32'h04, 32'h5566_7788);
    run_op(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("t4_rdata_held", rdata_o, 32'hFFFF_ABCD);
`else
    check("t4_forced", rdata_o, 32'h5566_7788);
`endif

    // Reset during the WR cycle of a byte store.
    run_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = 32'h41; wdata_i = 32'h0000_0012;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_we_in_rst", {31'd0, mem_we_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_no_done", {31'd0, done_o}, 32'd0);
    check("t5_ready", {31'd0, ready_o}, 32'd1);
    check("t5_rdata_rst", rdata_o, 32'h0);
    exp_rdata = 32'h0;
    @(posedge clk); #1;
    check("t5_no_done2", {31'd0, done_o}, 32'd0);
    check("t5_word", dmem[16], 32'hCAFE_F00D);
    // Back-to-back: each run_op returns in the done cycle of the previous.
    run_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    run_op(1'b0, 2'b00, 1'b1, 32'h43, 32'h0);
    check("t5_b2b", rdata_o, 32'h0000_00CA);

    // Random traffic over 16 words with random upper address bits (wrap).
    for (int i = 0; i < 120; i++) begin
      a = $urandom;
      a[13:6] = 8'h00;
      run_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
